sipo_deserializer: RTL

- Serial-in/parallel-out stage that sits directly downstream of the D latch/flop stage.
- Consumes the latched single-bit stream q (one bit per qualified clock) and assembles WIDTH-bit words.
- Presents each completed word on a held valid/ready output.
- Tracks bit position and flags dropped words (overrun).

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_deserializer_if.sv | 16 +
 rtl/sipo_shift_core.sv | 44 ++++
 rtl/sipo_deserializer.sv | 87 ++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants, output-state encoding and counter sizing for the
// serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam bit DEF_MSB_FIRST = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Bit counter width: clog2 of the word length, never narrower than 1.
    function automatic int cnt_w(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and held-word output handshake of the deserializer.
interface sipo_deserializer_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    // master: bit source and word consumer; slave: the deserializer
    modport master (output sin, sin_valid, dout_ready, input dout, dout_valid);
    modport slave  (input sin, sin_valid, dout_ready, output dout, dout_valid);
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit position counter. Emits the assembled word
// (including the bit sampled this edge) with a single-cycle word_done.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic             last;

    assign shifted   = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
    assign last      = (bit_cnt == CW'(WIDTH - 1));
    // Completion is masked by clr so a cleared edge never delivers a word.
    assign word_done = sin_valid & ~clr & last;
    assign word      = shifted;

    // Shift in one bit per qualified edge; counter wraps at the word boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sin_valid) begin
            sr      <= shifted;
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles WIDTH-bit words from a
// qualified bit stream and holds each on a valid/ready output, flagging
// words dropped while the consumer stalls.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    sipo_deserializer_if.slave bus,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun
);

    logic [WIDTH-1:0] word;
    logic             word_done;

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovr_d;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sin       (bus.sin),
        .sin_valid (bus.sin_valid),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    // Output state, held word and sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OUT_EMPTY;
            dout_q  <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            overrun <= ovr_d;
        end
    end

    // Next-state: load on completion when empty or when the held word is
    // accepted on the same edge; otherwise a completion is dropped.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ovr_d   = overrun;
        if (clr) begin
            // dout deliberately keeps its last value across a clear
            state_d = OUT_EMPTY;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (word_done) begin
                        dout_d  = word;
                        state_d = OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (word_done) begin
                        if (bus.dout_ready) dout_d = word;
                        else                ovr_d  = 1'b1;
                    end else if (bus.dout_ready) begin
                        state_d = OUT_EMPTY;
                    end
                end
                default: state_d = OUT_EMPTY;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == OUT_FULL);

endmodule
